cntr8_sched: RTL and testbench

Round-robin scheduler that shares one 8-bit up/down counter datapath between two requesters. Each requester issues a command (LOAD, INC, DEC or WAIT) with a run length and load data over a req/gnt handshake. The block arbitrates, drives the counter's load/inc/enable/data controls for the requested number of cycles, then pulses a per-requester done. It sits directly in front of the counter and is the only block that drives the counter's control inputs.

---
 rtl/cntr8_sched.sv | 139 +++++++++++++
 tb/tb_cntr8_sched.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cntr8_sched.sv
// Round-robin scheduler sharing one 8-bit up/down counter between two requesters.
// State | meaning: IDLE - arbitrate; RUN - drive counter for len cycles; DONE - pulse done.
module cntr8_sched (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [1:0] cmd0,
    input  logic [1:0] cmd1,
    input  logic [3:0] len0,
    input  logic [3:0] len1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic       busy,
    output logic       cnt_en,
    output logic       cnt_load,
    output logic       cnt_inc,
    output logic [7:0] cnt_d_in
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      r_state;
    logic        r_ptr;
    logic        r_id;
    logic [1:0]  r_cmd;
    logic [7:0]  r_data;
    logic [4:0]  r_rem;

    logic        w_any;
    logic        w_win;
    logic [1:0]  w_cmd;
    logic [3:0]  w_len;
    logic [7:0]  w_data;
    logic [1:0]  w_sel_cmd;
    logic [7:0]  w_sel_data;
    logic        w_en;
    logic        w_load;
    logic        w_inc;
    logic [7:0]  w_d;

    // On a tie the requester not served last wins.
    assign w_any  = req0 | req1;
    assign w_win  = req1 & (~req0 | ~r_ptr);
    assign w_cmd  = w_win ? cmd1  : cmd0;
    assign w_len  = w_win ? len1  : len0;
    assign w_data = w_win ? data1 : data0;

    // Entering RUN uses the winner's fresh command; staying in RUN uses the latched one.
    assign w_sel_cmd  = (r_state == S_IDLE) ? w_cmd  : r_cmd;
    assign w_sel_data = (r_state == S_IDLE) ? w_data : r_data;

    always_comb begin
        w_en   = (w_sel_cmd != 2'b00);
        w_load = (w_sel_cmd == 2'b01);
        w_inc  = (w_sel_cmd == 2'b10);
        w_d    = w_load ? w_sel_data : 8'h00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_ptr    <= 1'b1;
            r_id     <= 1'b0;
            r_cmd    <= 2'b00;
            r_data   <= 8'h00;
            r_rem    <= 5'd0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            busy     <= 1'b0;
            cnt_en   <= 1'b0;
            cnt_load <= 1'b0;
            cnt_inc  <= 1'b0;
            cnt_d_in <= 8'h00;
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state  <= S_RUN;
                        r_id     <= w_win;
                        r_cmd    <= w_cmd;
                        r_data   <= w_data;
                        r_rem    <= (w_len == 4'd0) ? 5'd16 : {1'b0, w_len};
                        gnt0     <= ~w_win;
                        gnt1     <= w_win;
                        busy     <= 1'b1;
                        cnt_en   <= w_en;
                        cnt_load <= w_load;
                        cnt_inc  <= w_inc;
                        cnt_d_in <= w_d;
                    end else begin
                        busy     <= 1'b0;
                        cnt_en   <= 1'b0;
                        cnt_load <= 1'b0;
                        cnt_inc  <= 1'b0;
                        cnt_d_in <= 8'h00;
                    end
                end
                S_RUN: begin
                    if (r_rem == 5'd1) begin
                        r_state  <= S_DONE;
                        done0    <= ~r_id;
                        done1    <= r_id;
                        cnt_en   <= 1'b0;
                        cnt_load <= 1'b0;
                        cnt_inc  <= 1'b0;
                        cnt_d_in <= 8'h00;
                    end else begin
                        r_rem    <= r_rem - 5'd1;
                        cnt_en   <= w_en;
                        cnt_load <= w_load;
                        cnt_inc  <= w_inc;
                        cnt_d_in <= w_d;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_ptr   <= r_id;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cntr8_sched.sv
// Bench for cntr8_sched: directed table, reset/tie sequences, then random traffic
// checked every cycle against a transaction-level expected-output queue.
module tb_cntr8_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [1:0] cmd0, cmd1;
    logic [3:0] len0, len1;
    logic [7:0] data0, data1;
    logic       gnt0, gnt1, done0, done1, busy;
    logic       cnt_en, cnt_load, cnt_inc;
    logic [7:0] cnt_d_in;

    cntr8_sched dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
        .len0(len0), .len1(len1), .data0(data0), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .busy(busy),
        .cnt_en(cnt_en), .cnt_load(cnt_load), .cnt_inc(cnt_inc), .cnt_d_in(cnt_d_in)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // The counter this block steers.
    logic [7:0] ctr = 8'h00;
    always @(posedge clk)
        if (cnt_en) ctr <= cnt_load ? cnt_d_in : (cnt_inc ? ctr + 8'd1 : ctr - 8'd1);

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    typedef struct packed {
        logic g0, g1, d0, d1, busy, en, load, inc;
        logic [7:0] d;
    } exp_t;

    // Reference: when idle and a request is seen, queue the whole N+1 cycle response.
    exp_t exp_q[$];
    bit   m_ptr = 1'b1;

    initial forever begin
        exp_t e, a, x;
        bit   w;
        int   n;
        logic [1:0] c;
        logic [7:0] dd;
        @(negedge clk);
        if (reset) begin
            exp_q.delete();
            m_ptr = 1'b1;
            e = '0;
        end else if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '0;
        a = {gnt0, gnt1, done0, done1, busy, cnt_en, cnt_load, cnt_inc, cnt_d_in};
        check("cycle_outputs", 32'(a), 32'(e));
        if (!reset && !e.busy && exp_q.size() == 0 && (req0 || req1)) begin
            w  = (req0 && req1) ? !m_ptr : req1;
            c  = w ? cmd1 : cmd0;
            n  = int'(w ? len1 : len0);
            if (n == 0) n = 16;
            dd = w ? data1 : data0;
            for (int k = 0; k < n; k++) begin
                x      = '0;
                x.busy = 1'b1;
                x.g0   = (k == 0) && !w;
                x.g1   = (k == 0) && w;
                x.en   = (c != 2'd0);
                x.load = (c == 2'd1);
                x.inc  = (c == 2'd2);
                x.d    = (c == 2'd1) ? dd : 8'h00;
                exp_q.push_back(x);
            end
            x      = '0;
            x.busy = 1'b1;
            x.d0   = !w;
            x.d1   = w;
            exp_q.push_back(x);
            m_ptr = w;
        end
    end

    typedef struct {
        bit         id;
        logic [1:0] cmd;
        logic [3:0] len;
        logic [7:0] data;
        int         exp_en;
        int         exp_done;
        logic [7:0] exp_ctr;
    } vec_t;

    vec_t tbl[7];

    task automatic run_cmd(input vec_t v);
        int t0, tg, td, tbz, en_cnt;
        tg = -1; td = -1; tbz = -1; en_cnt = 0;
        @(posedge clk); #2;
        if (v.id) begin req1 = 1'b1; cmd1 = v.cmd; len1 = v.len; data1 = v.data; end
        else      begin req0 = 1'b1; cmd0 = v.cmd; len0 = v.len; data0 = v.data; end
        t0 = cyc;
        for (int k = 0; k < 40 && tbz < 0; k++) begin
            @(negedge clk);
            if ((v.id ? gnt1 : gnt0) && tg < 0) tg = cyc - t0;
            if (cnt_en) en_cnt++;
            if (v.id ? done1 : done0) td = cyc - t0;
            if (td >= 0 && !busy) tbz = cyc - t0;
            @(posedge clk); #2;
            if (tg >= 0) begin req0 = 1'b0; req1 = 1'b0; end
        end
        check("gnt_latency", 32'(tg), 32'd1);
        check("cnt_en_cycles", 32'(en_cnt), 32'(v.exp_en));
        check("done_latency", 32'(td), 32'(v.exp_done));
        check("busy_fall", 32'(tbz), 32'(v.exp_done + 1));
        check("counter_value", 32'(ctr), 32'(v.exp_ctr));
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40 && busy; k++) @(negedge clk);
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    initial begin
        int   ng, last_done, dcount;
        logic [7:0] ord [4];
        exp_t a;
        ord = '{8'd0, 8'd1, 8'd0, 8'd1};

        tbl[0] = '{1'b0, 2'b01, 4'd1, 8'hA5,  1,  2, 8'hA5};
        tbl[1] = '{1'b1, 2'b10, 4'd5, 8'h00,  5,  6, 8'hAA};
        tbl[2] = '{1'b0, 2'b01, 4'd2, 8'h05,  2,  3, 8'h05};
        tbl[3] = '{1'b0, 2'b11, 4'd0, 8'h00, 16, 17, 8'hF5};
        tbl[4] = '{1'b1, 2'b00, 4'd3, 8'h77,  0,  4, 8'hF5};
        tbl[5] = '{1'b1, 2'b11, 4'd4, 8'h00,  4,  5, 8'hF1};
        tbl[6] = '{1'b0, 2'b01, 4'd0, 8'h3C, 16, 17, 8'h3C};

        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; cmd0 = 2'b00; cmd1 = 2'b00;
        len0 = 4'd0; len1 = 4'd0; data0 = 8'h00; data1 = 8'h00;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        foreach (tbl[i]) run_cmd(tbl[i]);

        // Abort an INC len=8 in its third RUN cycle; last served is requester 0 here.
        @(posedge clk); #2;
        req0 = 1'b1; cmd0 = 2'b10; len0 = 4'd8; data0 = 8'h00;
        @(posedge clk); #2;
        req0 = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        check("rst_pre_cnt_en", 32'(cnt_en), 32'd1);
        reset = 1'b1;
        #1;
        a = {gnt0, gnt1, done0, done1, busy, cnt_en, cnt_load, cnt_inc, cnt_d_in};
        check("rst_outputs_zero", 32'(a), 32'd0);
        @(posedge clk); #2;
        @(posedge clk); #2;
        reset = 1'b0;
        dcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (done0 || done1) dcount++;
        end
        check("rst_no_done", 32'(dcount), 32'd0);

        // Held tie after reset: strict alternation starting with requester 0.
        @(posedge clk); #2;
        req0 = 1'b1; cmd0 = 2'b10; len0 = 4'd2; data0 = 8'h00;
        req1 = 1'b1; cmd1 = 2'b11; len1 = 4'd3; data1 = 8'h00;
        ng = 0; last_done = -100;
        for (int k = 0; k < 60 && ng < 4; k++) begin
            @(negedge clk);
            if (done0 || done1) last_done = cyc;
            if (gnt0 || gnt1) begin
                check("tie_order", 32'(gnt1), 32'(ord[ng]));
                if (ng > 0) check("gnt_after_done", 32'(cyc - last_done), 32'd2);
                ng++;
            end
        end
        check("tie_grant_count", 32'(ng), 32'd4);
        @(posedge clk); #2;
        req0 = 1'b0; req1 = 1'b0;
        wait_idle();

        // Random traffic with occasional resets; the per-cycle model does the checking.
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #2;
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 299) == 0) reset = 1'b1;
            if (gnt0 && $urandom_range(0, 3) != 0) req0 = 1'b0;
            if (gnt1 && $urandom_range(0, 3) != 0) req1 = 1'b0;
            if (!req0 && $urandom_range(0, 2) == 0) begin
                req0 = 1'b1; cmd0 = 2'($urandom_range(0, 3));
                len0 = 4'($urandom_range(0, 15)); data0 = 8'($urandom_range(0, 255));
            end
            if (!req1 && $urandom_range(0, 2) == 0) begin
                req1 = 1'b1; cmd1 = 2'($urandom_range(0, 3));
                len1 = 4'($urandom_range(0, 15)); data1 = 8'($urandom_range(0, 255));
            end
        end
        @(posedge clk); #2;
        reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (25) @(posedge clk);
        @(negedge clk);
        check("final_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
